lock_controller: RTL and testbench
==================================

# lock_controller

Downstream stage of the passcode sequence detector. Consumes the detector's one-cycle match pulse plus an attempt-boundary strobe, and drives the physical lock. Holds the lock open for a fixed time after a correct code, counts consecutive wrong attempts, and forces a timed lockout with an alarm pulse once the failure limit is reached.

## Interface
- `UNLOCK_CYCLES`, default 16: cycles the lock stays open after a success; range 1..65535.
- `MAX_FAILS`, default 3: consecutive failures that trigger lockout; range 1..15.
- `LOCKOUT_CYCLES`, default 64: lockout duration in cycles; range 1..65535.

Ports:
- `clk`  in  1  single clock, rising edge.
- `asyncReset`  in  1  asynchronous, active-high reset.
- `detectIn`  in  1  one-cycle pulse from the detector: a correct code was seen.
- `attemptDone`  in  1  one-cycle pulse: one 4-bit attempt has finished.
- `lockReq`  in  1  manual relock request; used only with `MANUAL_RELOCK_EN`.
- `unlocked`  out  1  high while the lock is open.
- `lockoutActive`  out  1  high while in lockout.
- `failCount`  out  4  current consecutive-failure count.
- `alarm`  out  1  one-cycle pulse on entry to lockout.

## Operation
- Three states: LOCKED, UNLOCKED and LOCKOUT. Use binary encoding. Reset state is LOCKED.
- Timer: one down-counter shared by UNLOCKED and LOCKOUT. Width is `$clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1)`.
- **LOCKED:**
  - `detectIn`=1 gives a success, whether or not `attemptDone` is high. On success: go to UNLOCKED, load the timer with `UNLOCK_CYCLES`, and clear `failCount` to 0.
  - `attemptDone`=1 with `detectIn`=0 gives a failure. `failCount` increments.
  - If the incremented count equals `MAX_FAILS`: go to LOCKOUT, load the timer with `LOCKOUT_CYCLES`, pulse `alarm`, and keep `failCount`=`MAX_FAILS`.
  - No input high: hold state.
- **UNLOCKED:**
  - Timer decrements each cycle. When the timer is 1 and decrements, go to LOCKED.
  - `detectIn`=1 reloads the timer with `UNLOCK_CYCLES`, so the lock stays open.
  - `attemptDone` alone is ignored. Wrong codes while open are not counted.
- **LOCKOUT:**
  - `detectIn` and `attemptDone` are ignored.
  - Timer decrements. On expiry go to LOCKED and clear `failCount` to 0.
- `failCount` never exceeds `MAX_FAILS`, and never wraps.
- Reset mid-operation: state becomes LOCKED, the timer and all outputs clear immediately, and any pending lockout is abandoned.

## Timing
- Every output is a register. Reset value of every output is 0.
- Success: `detectIn` high at edge t causes `unlocked`=1 from t+1 through t+`UNLOCK_CYCLES`, and 0 at t+`UNLOCK_CYCLES`+1.
- Retrigger: `detectIn` at edge u while UNLOCKED causes `unlocked` to stay 1 through u+`UNLOCK_CYCLES`.
- Failure: `failCount` updates at t+1.
- Lockout entry: happens at t+1 on the failing edge t.
  - `alarm`=1 for exactly cycle t+1.
  - `lockoutActive`=1 from t+1 through t+`LOCKOUT_CYCLES`.
  - `failCount`=0 from t+`LOCKOUT_CYCLES`+1.
- `unlocked` and `lockoutActive` are never high together.
- Input pulses longer than one cycle are treated as one event per cycle high. Upstream guarantees single-cycle pulses.

## Configuration
- `MANUAL_RELOCK_EN` defined:
  - In UNLOCKED, `lockReq`=1 at edge t forces LOCKED with `unlocked`=0 at t+1, and clears the timer.
  - If `lockReq` and `detectIn` are both high in the same cycle, `lockReq` wins.
  - `lockReq` has no effect in LOCKED or LOCKOUT.
- `MANUAL_RELOCK_EN` undefined:
  - `lockReq` is ignored. The port remains present and is unconnected internally.
  - The lock only closes on timer expiry.

## Test plan
All scenarios use default parameters.
- **Reset:** assert `asyncReset` mid-cycle while UNLOCKED. All outputs read 0 immediately, with no clock edge needed. State is LOCKED after release.
- **Success:** `detectIn` pulse at edge 10. `unlocked`=1 on cycles 11–26, and 0 at 27. `failCount`=0.
- **Retrigger:** `detectIn` at edge 10, then again at edge 20. `unlocked` holds 1 through cycle 36.
- **Lockout:**
  - `attemptDone` without `detectIn` at edges 5, 10 and 15 gives `failCount` 1, 2, 3.
  - `alarm`=1 only at cycle 16. `lockoutActive`=1 on cycles 16–79.
  - `failCount`=0 at 80.
  - `detectIn` at edge 30 has no effect.
- **Simultaneous and reset-of-count:**
  - Two failures, then `attemptDone`+`detectIn` in the same cycle: gives a success, and `failCount`=0.
  - A further single failure then gives `failCount`=1, with no lockout.
- **Manual relock** (`MANUAL_RELOCK_EN` on): `detectIn` at edge 10, `lockReq` at edge 14 gives `unlocked`=0 at 15. With the macro off, the same stimulus keeps `unlocked`=1 through 26.

Source files
------------

// File: rtl/lock_controller.sv
// ============================================================================
// Module   : lock_controller
// Brief    : Drives the physical lock from detector match / attempt strobes.
//            It opens the lock for a timed window, counts consecutive
//            failures, and forces a timed lockout with an alarm pulse.
//            Optional feature macro: MANUAL_RELOCK_EN (lockReq closes early).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_controller #(
  parameter int UNLOCK_CYCLES  = 16,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       asyncReset,
  input  logic       detectIn,
  input  logic       attemptDone,
  input  logic       lockReq,
  output logic       unlocked,
  output logic       lockoutActive,
  output logic [3:0] failCount,
  output logic       alarm
);

  localparam int C_MAX_CYCLES = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int C_TW         = $clog2(C_MAX_CYCLES + 1);

  localparam logic [C_TW-1:0] C_UNLOCK_LOAD  = C_TW'(UNLOCK_CYCLES);
  localparam logic [C_TW-1:0] C_LOCKOUT_LOAD = C_TW'(LOCKOUT_CYCLES);
  localparam logic [C_TW-1:0] C_TIMER_ONE    = C_TW'(1);
  localparam logic [3:0]      C_MAX_FAILS    = 4'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_e;

  state_e          state_q;
  logic [C_TW-1:0] timer_q;
  logic [3:0]      fail_q;
  logic            unlocked_q;
  logic            lockout_q;
  logic            alarm_q;

  logic [3:0]      w_fail_inc;
  logic            w_relock;

  assign w_fail_inc = fail_q + 4'd1;

`ifdef MANUAL_RELOCK_EN
  assign w_relock = lockReq;
`else
  logic w_unused_lockreq;
  assign w_unused_lockreq = lockReq;
  assign w_relock         = 1'b0;
`endif

  always_ff @(posedge clk or posedge asyncReset) begin
    if (asyncReset) begin
      state_q    <= ST_LOCKED;
      timer_q    <= '0;
      fail_q     <= '0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      alarm_q <= 1'b0;
      case (state_q)
        ST_LOCKED: begin
          // A match wins over a coincident attempt strobe.
          if (detectIn) begin
            state_q    <= ST_UNLOCKED;
            timer_q    <= C_UNLOCK_LOAD;
            fail_q     <= '0;
            unlocked_q <= 1'b1;
          end else if (attemptDone) begin
            if (w_fail_inc >= C_MAX_FAILS) begin
              state_q   <= ST_LOCKOUT;
              timer_q   <= C_LOCKOUT_LOAD;
              fail_q    <= C_MAX_FAILS;
              lockout_q <= 1'b1;
              alarm_q   <= 1'b1;
            end else begin
              fail_q <= w_fail_inc;
            end
          end
        end
        ST_UNLOCKED: begin
          if (w_relock || timer_q <= C_TIMER_ONE) begin
            if (!w_relock && detectIn) begin
              timer_q <= C_UNLOCK_LOAD;
            end else begin
              state_q    <= ST_LOCKED;
              timer_q    <= '0;
              unlocked_q <= 1'b0;
            end
          end else if (detectIn) begin
            timer_q <= C_UNLOCK_LOAD;
          end else begin
            timer_q <= timer_q - C_TIMER_ONE;
          end
        end
        ST_LOCKOUT: begin
          if (timer_q <= C_TIMER_ONE) begin
            state_q   <= ST_LOCKED;
            timer_q   <= '0;
            fail_q    <= '0;
            lockout_q <= 1'b0;
          end else begin
            timer_q <= timer_q - C_TIMER_ONE;
          end
        end
        default: begin
          state_q    <= ST_LOCKED;
          timer_q    <= '0;
          fail_q     <= '0;
          unlocked_q <= 1'b0;
          lockout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign unlocked      = unlocked_q;
  assign lockoutActive = lockout_q;
  assign failCount     = fail_q;
  assign alarm         = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_lock_controller.sv
// ============================================================================
// Module   : tb_lock_controller
// Brief    : Scoreboard bench for lock_controller with directed scenarios.
//            Honours MANUAL_RELOCK_EN when compiled alongside the RTL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lock_controller;

  logic       clk;
  logic       asyncReset;
  logic       detectIn;
  logic       attemptDone;
  logic       lockReq;
  logic       unlocked;
  logic       lockoutActive;
  logic [3:0] failCount;
  logic       alarm;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         scen;
    int         step;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];

  lock_controller #(
    .UNLOCK_CYCLES (16),
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(64)
  ) dut (
    .clk          (clk),
    .asyncReset   (asyncReset),
    .detectIn     (detectIn),
    .attemptDone  (attemptDone),
    .lockReq      (lockReq),
    .unlocked     (unlocked),
    .lockoutActive(lockoutActive),
    .failCount    (failCount),
    .alarm        (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_r(int k, int lo, int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  // Step k drives the inputs seen by edge k and queues the outputs expected after it.
  task automatic drive(input int scen, input int k, input bit d, input bit a, input bit r,
                       input bit u, input bit l, input int f, input bit al);
    exp_t e;
    @(negedge clk);
    detectIn    = d;
    attemptDone = a;
    lockReq     = r;
    e.scen = scen;
    e.step = k;
    e.exp  = {u, l, 4'(f), al};
    sb.push_back(e);
  endtask

  task automatic reset_mid(input int scen);
    @(posedge clk);
    #3;
    asyncReset  = 1'b1;
    detectIn    = 1'b0;
    attemptDone = 1'b0;
    lockReq     = 1'b0;
    #1;
    n_cmp++;
    if ({unlocked, lockoutActive, failCount, alarm} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_async scen%0d got %b want %b", scen,
               {unlocked, lockoutActive, failCount, alarm}, 7'b0);
    end
    repeat (2) @(negedge clk);
    asyncReset = 1'b0;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {unlocked, lockoutActive, failCount, alarm};
        n_cmp++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL sb scen%0d step%0d got {unl,lo,fc,al}=%b want %b",
                   e.scen, e.step, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int f;
    detectIn    = 1'b0;
    attemptDone = 1'b0;
    lockReq     = 1'b0;
    asyncReset  = 1'b0;
    #2;
    asyncReset = 1'b1;
    #1;
    n_cmp++;
    if ({unlocked, lockoutActive, failCount, alarm} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_init got %b want %b", {unlocked, lockoutActive, failCount, alarm}, 7'b0);
    end
    repeat (2) @(negedge clk);
    asyncReset = 1'b0;

    // 1: single success at edge 10, open for cycles 11..26
    for (int k = 1; k <= 30; k++)
      drive(1, k, k == 10, 1'b0, 1'b0, in_r(k, 10, 25), 1'b0, 0, 1'b0);
    reset_mid(1);

    // 2: retrigger at edge 20 extends open window through cycle 36
    for (int k = 1; k <= 40; k++)
      drive(2, k, (k == 10) || (k == 20), 1'b0, 1'b0, in_r(k, 10, 35), 1'b0, 0, 1'b0);
    reset_mid(2);

    // 3: three failures -> lockout cycles 16..79, detect at 30 ignored, fresh count after
    for (int k = 1; k <= 85; k++) begin
      f = (k >= 82) ? 1 : (k >= 79) ? 0 : (k >= 15) ? 3 : (k >= 10) ? 2 : (k >= 5) ? 1 : 0;
      drive(3, k, k == 30, (k == 5) || (k == 10) || (k == 15) || (k == 82), 1'b0,
            1'b0, in_r(k, 15, 78), f, k == 15);
    end
    reset_mid(3);

    // 4: simultaneous detect+attempt is a success; attempt while open ignored
    for (int k = 1; k <= 36; k++) begin
      f = (k >= 30) ? 1 : (k >= 9) ? 0 : (k >= 6) ? 2 : (k >= 3) ? 1 : 0;
      drive(4, k, k == 9, (k == 3) || (k == 6) || (k == 9) || (k == 15) || (k == 30), 1'b0,
            in_r(k, 9, 24), 1'b0, f, 1'b0);
    end
    reset_mid(4);

    // 5: manual relock, including lockReq coincident with detectIn
    for (int k = 1; k <= 42; k++) begin
`ifdef MANUAL_RELOCK_EN
      drive(5, k, (k == 10) || (k == 20) || (k == 22), 1'b0, (k == 2) || (k == 14) || (k == 22),
            in_r(k, 10, 13) || in_r(k, 20, 21), 1'b0, 0, 1'b0);
`else
      drive(5, k, (k == 10) || (k == 20) || (k == 22), 1'b0, (k == 2) || (k == 14) || (k == 22),
            in_r(k, 10, 37), 1'b0, 0, 1'b0);
`endif
    end
    reset_mid(5);

    // 6: reset mid-UNLOCKED, then state must be LOCKED (attempt counts)
    for (int k = 1; k <= 6; k++)
      drive(6, k, k == 3, 1'b0, 1'b0, k >= 3, 1'b0, 0, 1'b0);
    reset_mid(6);
    for (int k = 1; k <= 8; k++)
      drive(7, k, 1'b0, k == 4, 1'b0, 1'b0, 1'b0, (k >= 4) ? 1 : 0, 1'b0);
    reset_mid(7);

    // 8: reset during lockout abandons it immediately
    for (int k = 1; k <= 5; k++)
      drive(8, k, 1'b0, k <= 3, 1'b0, 1'b0, k >= 3, (k >= 3) ? 3 : k, k == 3);
    reset_mid(8);
    for (int k = 1; k <= 4; k++)
      drive(9, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
